// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types and encodings.
// Imported by inst_fetch and if_id.
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int StallBus    = 6;

  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ReadDisable = 1'b0;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
    logic                   adel;
  } if_id_t;

  localparam if_id_t Bubble = '{pc: '0, inst: '0, adel: 1'b0};

  function automatic logic misaligned(
    input logic [InstAddrBus-1:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_id.sv
// IF/ID pipeline register with bubble insertion
// and accepted-instruction counter.
module if_id
  import inst_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:1]             stall,
  input  logic                   flush,
  input  logic                   rom_ce,
  input  logic [InstAddrBus-1:0] pc,
  input  logic [InstBus-1:0]     inst,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o,
  output logic                   id_adel_o,
  output logic [31:0]            fetch_count_o
);

  if_id_t q;
  if_id_t fetched;

  always_comb begin
    fetched.pc   = pc;
    fetched.adel = misaligned(pc);
    fetched.inst = fetched.adel ? ZeroWord : inst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q             <= Bubble;
      fetch_count_o <= '0;
    end else if (flush || rom_ce == ReadDisable) begin
      q <= Bubble;
    end else if (stall[1] == NoStop) begin
      q             <= fetched;
      fetch_count_o <= fetch_count_o + 32'd1;
    end else if (stall[2] == NoStop) begin
      // IF stalled but ID moving: feed ID a bubble
      q <= Bubble;
    end
  end

  assign id_pc_o   = q.pc;
  assign id_inst_o = q.inst;
  assign id_adel_o = q.adel;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, deferred
// branches under stall, and the IF/ID register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [StallBus-1:0]    stall,
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_address_i,
  input  logic [InstBus-1:0]     inst_i,
  output logic                   rom_ce_o,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o,
  output logic                   id_adel_o,
  output logic [31:0]            fetch_count_o
);

  fetch_state_t           state;
  logic                   pend_vld;
  logic [InstAddrBus-1:0] pend_tgt;
  logic [InstAddrBus-1:0] pc_next;
  logic                   unused_stall;

  assign unused_stall = ^stall[StallBus-1:3];

  always_comb begin
    pc_next = pc_o + 32'd4;
    if (flush)
      pc_next = new_pc;
    else if (stall[0] == Stop)
      pc_next = pc_o;
    else if (pend_vld)
      pc_next = pend_tgt;
    else if (branch_flag_i)
      pc_next = branch_target_address_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_ce_o <= ReadDisable;
      pc_o     <= RESET_PC;
      pend_vld <= 1'b0;
      pend_tgt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= RUN;
          rom_ce_o <= ChipEnable;
        end
        RUN: begin
          pc_o <= pc_next;
          // branch seen while PC held is replayed on release
          if (flush) begin
            pend_vld <= 1'b0;
          end else if (stall[0] == Stop) begin
            if (branch_flag_i) begin
              pend_vld <= 1'b1;
              pend_tgt <= branch_target_address_i;
            end
          end else begin
            pend_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_id u_if_id (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall[2:1]),
    .flush         (flush),
    .rom_ce        (rom_ce_o),
    .pc            (pc_o),
    .inst          (inst_i),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_adel_o     (id_adel_o),
    .fetch_count_o (fetch_count_o)
  );

endmodule
